flop_wr_arb: RTL and testbench

Shared-write controller for a bank of 4-bit resettable registers. Arbitrates up to N_REQ requesters contending for write access, commits at most one write per clock, returns a registered acknowledge, and exposes the bank contents for read-back. Sits between datapath producers and the register bank. The bank is internal to this block, built from synchronously reset flops.

---
 rtl/flop_wr_arb.sv | 131 +++++++++++++
 tb/tb_flop_wr_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flop_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : flop_wr_arb
// Purpose : Shared-write arbiter in front of an internal resettable register
//           bank. One write commits per clock, with a registered ack, and the
//           bank contents are exposed for read-back.
//           Define FLOP_ARB_RR_EN for round-robin arbitration; fixed priority
//           (requester 0 highest) otherwise.
// Revision: 1.0 - initial release
// ============================================================================
module flop_wr_arb #(
    parameter int  N_REQ = 4,
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*AW-1:0]    i_addr,
    input  logic [N_REQ*WIDTH-1:0] i_data,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_ack,
    input  logic [AW-1:0]          i_rd_addr,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic [DEPTH*WIDTH-1:0] o_q,
    output logic [7:0]             o_wr_count
);

    logic [N_REQ-1:0]            w_gnt_raw;
    logic [N_REQ-1:0]            w_gnt;
    logic                        w_wr_en;
    logic [AW-1:0]               w_wr_addr;
    logic [WIDTH-1:0]            w_wr_data;
    logic [DEPTH-1:0][WIDTH-1:0] r_bank_q;
    logic [DEPTH-1:0][WIDTH-1:0] w_bank_d;
    logic [N_REQ-1:0]            r_ack_q;
    logic [N_REQ-1:0]            w_ack_d;
    logic [7:0]                  r_wr_count_q;
    logic [7:0]                  w_wr_count_d;

`ifdef FLOP_ARB_RR_EN
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] r_ptr_q;
    logic [PW-1:0] w_ptr_d;

    // Search upward from the pointer with wrap; the pointer then moves just
    // past the winner so it becomes lowest priority next time.
    always_comb begin
        logic found;
        int   idx;
        w_gnt_raw = '0;
        w_ptr_d   = r_ptr_q;
        found     = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(r_ptr_q) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && i_req[idx]) begin
                found          = 1'b1;
                w_gnt_raw[idx] = 1'b1;
                w_ptr_d        = (idx == N_REQ - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end
`else
    // Descending scan: the lowest asserted index is written last and wins.
    always_comb begin
        w_gnt_raw = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_gnt_raw    = '0;
                w_gnt_raw[k] = 1'b1;
            end
        end
    end
`endif

    assign w_gnt   = i_reset ? '0 : w_gnt_raw;
    assign w_wr_en = |w_gnt;

    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_wr_addr = i_addr[k*AW +: AW];
                w_wr_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_bank_d = r_bank_q;
        if (w_wr_en) begin
            w_bank_d[w_wr_addr] = w_wr_data;
        end
        w_ack_d      = w_gnt;
        w_wr_count_d = r_wr_count_q + {7'd0, w_wr_en};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bank_q     <= '0;
            r_ack_q      <= '0;
            r_wr_count_q <= '0;
        end else begin
            r_bank_q     <= w_bank_d;
            r_ack_q      <= w_ack_d;
            r_wr_count_q <= w_wr_count_d;
        end
    end

    assign o_gnt      = w_gnt;
    assign o_ack      = r_ack_q;
    assign o_rd_data  = r_bank_q[i_rd_addr];
    assign o_q        = r_bank_q;
    assign o_wr_count = r_wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_flop_wr_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_flop_wr_arb
// Purpose : Self-checking bench for flop_wr_arb (4 requesters, 4 x 4-bit bank).
// Revision: 1.0 - initial release
// ============================================================================
module tb_flop_wr_arb;

    localparam int N = 4;

    logic        i_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  rd_addr;
    logic [3:0]  o_gnt;
    logic [3:0]  o_ack;
    logic [3:0]  o_rd_data;
    logic [15:0] o_q;
    logic [7:0]  o_wr_count;

    flop_wr_arb #(.N_REQ(4), .DEPTH(4), .WIDTH(4)) dut (
        .i_clk      (i_clk),
        .i_reset    (rst),
        .i_req      (req),
        .i_addr     (addr),
        .i_data     (data),
        .o_gnt      (o_gnt),
        .o_ack      (o_ack),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (o_rd_data),
        .o_q        (o_q),
        .o_wr_count (o_wr_count)
    );

    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [3:0] m_bank [4];
    logic [3:0] m_ack;
    int         m_ptr;
    int         m_count;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [1:0]  rd;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rd;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] model_gnt(input logic [3:0] r, input int p, input logic rs);
        int k;
        if (rs) return 4'b0000;
        for (int o = 0; o < N; o++) begin
`ifdef FLOP_ARB_RR_EN
            k = (p + o) % N;
`else
            k = o;
`endif
            if (r[k]) return 4'(1 << k);
        end
        return 4'b0000;
    endfunction

    function automatic logic [15:0] model_q();
        logic [15:0] v;
        for (int r = 0; r < 4; r++) v[r*4 +: 4] = m_bank[r];
        return v;
    endfunction

    // Caller drives inputs right after a falling edge; checks, clocks, updates model.
    task automatic cycle();
        logic [3:0] g;
        int k;
        #1;
        g = model_gnt(req, m_ptr, rst);
        chk("gnt",      32'(o_gnt),      32'(g));
        chk("ack",      32'(o_ack),      32'(m_ack));
        chk("count",    32'(o_wr_count), 32'(m_count));
        chk("rd_data",  32'(o_rd_data),  32'(m_bank[rd_addr]));
        chk("q",        32'(o_q),        32'(model_q()));
        @(posedge i_clk);
        if (rst) begin
            for (int r = 0; r < 4; r++) m_bank[r] = 4'h0;
            m_ptr = 0; m_ack = 4'b0; m_count = 0;
        end else if (g != 4'b0) begin
            k = 0;
            for (int i = 0; i < N; i++) if (g[i]) k = i;
            m_bank[addr[k*2 +: 2]] = data[k*4 +: 4];
            m_ack   = g;
            m_count = (m_count + 1) % 256;
            m_ptr   = (k + 1) % N;
        end else begin
            m_ack = 4'b0;
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; addr = '0; data = '0; rd_addr = '0;
        for (int r = 0; r < 4; r++) m_bank[r] = 4'hx;
        m_ack = 4'bx; m_ptr = 0; m_count = 0;
        @(posedge i_clk);
        for (int r = 0; r < 4; r++) m_bank[r] = 4'h0;
        m_ack = 4'b0;
        @(negedge i_clk);
        rst = 1'b0;

        // Single-cycle vectors, each from a fresh reset (pointer 0).
        tbl[0] = '{4'b0100, 8'h30, 16'h0A00, 2'd3, 4'b0100, 4'hA};
        tbl[1] = '{4'b0000, 8'h00, 16'h0000, 2'd0, 4'b0000, 4'h0};
        tbl[2] = '{4'b1011, 8'hC9, 16'h3F27, 2'd1, 4'b0001, 4'h7};
        tbl[3] = '{4'b1000, 8'h80, 16'hE000, 2'd2, 4'b1000, 4'hE};
        tbl[4] = '{4'b0110, 8'h30, 16'h0490, 2'd0, 4'b0010, 4'h9};
        for (int t = 0; t < 5; t++) begin
            do_reset();
            req = tbl[t].req; addr = tbl[t].addr; data = tbl[t].data; rd_addr = tbl[t].rd;
            #1;
            chk($sformatf("tbl%0d_gnt", t), 32'(o_gnt), 32'(tbl[t].exp_gnt));
            chk($sformatf("tbl%0d_rd_old", t), 32'(o_rd_data), 32'h0);
            cycle();
            req = 4'b0;
            #1;
            chk($sformatf("tbl%0d_ack", t), 32'(o_ack), 32'(tbl[t].exp_gnt));
            chk($sformatf("tbl%0d_rd", t), 32'(o_rd_data), 32'(tbl[t].exp_rd));
            chk($sformatf("tbl%0d_cnt", t), 32'(o_wr_count), 32'(|tbl[t].exp_gnt));
            cycle();
        end

        // Reset after preload with all requesters active.
        do_reset();
        req = 4'b1111; addr = 8'hE4; data = 16'h9C35;
        for (int i = 0; i < 4; i++) cycle();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        cycle();
        rst = 1'b0; req = 4'b0;
        #1;
        chk("rst_q", 32'(o_q), 32'h0);
        chk("rst_ack", 32'(o_ack), 32'h0);
        chk("rst_cnt", 32'(o_wr_count), 32'h0);
        cycle();

        // Arbitration policy under continuous contention.
        do_reset();
        req = 4'b1111; addr = 8'h1B; data = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef FLOP_ARB_RR_EN
            chk($sformatf("rr_gnt%0d", i), 32'(o_gnt), 32'(1 << (i % 4)));
`else
            chk($sformatf("fp_gnt%0d", i), 32'(o_gnt), 32'h1);
`endif
            cycle();
        end
        req = 4'b0;
        #1;
        chk("fair_cnt", 32'(o_wr_count), 32'd8);
        cycle();
`ifndef FLOP_ARB_RR_EN
        do_reset();
        req = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("fp1011_gnt%0d", i), 32'(o_gnt), 32'h1);
            cycle();
            chk($sformatf("fp1011_ack%0d", i), 32'(o_ack & 4'b1010), 32'h0);
        end
        req = 4'b0;
        cycle();
`endif

        // Same-address collision: grant order decides the final value.
        do_reset();
        req = 4'b0011; addr = 8'h05; data = 16'h00C5; rd_addr = 2'd1;
        #1;
        chk("coll_gnt0", 32'(o_gnt), 32'h1);
        cycle();
        req = 4'b0010;
        #1;
        chk("coll_gnt1", 32'(o_gnt), 32'h2);
        chk("coll_ack0", 32'(o_ack), 32'h1);
        chk("coll_mid", 32'(o_rd_data), 32'h5);
        cycle();
        req = 4'b0;
        #1;
        chk("coll_ack1", 32'(o_ack), 32'h2);
        chk("coll_final", 32'(o_rd_data), 32'hC);
        cycle();

        // Counter wrap after 256 commits.
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i % 4); data = 16'(i); rd_addr = 2'(i % 4);
            cycle();
        end
        req = 4'b0;
        #1;
        chk("wrap_cnt", 32'(o_wr_count), 32'h0);
        cycle();

        // Reset on edge 100 of a stream commits nothing and restarts the count.
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 110; i++) begin
            rst = (i == 100);
            addr = 8'(i << 4); data = 16'(i << 8);
            if (i == 100) begin
                #1;
                chk("mid_pre_cnt", 32'(o_wr_count), 32'd99);
            end
            if (i == 101) begin
                #1;
                chk("mid_rst_cnt", 32'(o_wr_count), 32'd0);
                chk("mid_rst_gnt", 32'(o_gnt), 32'h4);
            end
            cycle();
        end
        rst = 1'b0; req = 4'b0;
        #1;
        chk("mid_end_cnt", 32'(o_wr_count), 32'd10);
        cycle();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 39) == 0);
            req     = 4'($urandom_range(0, 15));
            addr    = 8'($urandom);
            data    = 16'($urandom);
            rd_addr = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
